// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions used by the panel receiver and the matrix driver.
package hub75_pkg;

  localparam int HUB75_WIDTH  = 64;
  localparam int HUB75_ROWS   = 32;
  localparam int HUB75_ADDR_W = 5;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // One shifted column: upper-half and lower-half pixel.
  typedef struct packed {
    rgb_t upper;
    rgb_t lower;
  } line_pix_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EMIT_UPPER = 2'd1,
    EMIT_LOWER = 2'd2
  } emit_state_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// N-stage synchronizer for asynchronous HUB75 pins, with a history flop for
// rise/fall/any-edge detection on the synchronized value.
module hub75_sync_edge #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clock_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o,
  output logic [W-1:0] any_o
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] hist_q;

  // No reset: the chain settles to the pin level while reset is held,
  // so no spurious edge appears when reset releases.
  always_ff @(posedge clock_i) begin
    stage_q[0] <= async_i;
    for (int i = 1; i < STAGES; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
    hist_q <= stage_q[STAGES-1];
  end

  assign sync_o = stage_q[STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;
  assign any_o  = sync_o ^ hist_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel emulator: captures shifted row pairs into a ping-pong line
// buffer and replays them on latch as a valid/ready pixel stream.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int WIDTH          = HUB75_WIDTH,
  parameter int ROWS           = HUB75_ROWS,
  parameter int SYNC_STAGES    = 2,
  parameter bit LATCH_ANY_EDGE = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [$clog2(ROWS)-1:0]     hub_addr,
  input  logic                        hub_clk,
  input  logic [2:0]                  hub_rgb1,
  input  logic [2:0]                  hub_rgb2,
  input  logic                        hub_oe,
  input  logic                        hub_lat,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [$clog2(WIDTH)-1:0]    pix_x,
  output logic [$clog2(2*ROWS)-1:0]   pix_y,
  output logic [2:0]                  pix_rgb,
  output logic                        pix_sof,
  output logic                        panel_on,
  output logic [15:0]                 rows_latched,
  output logic                        overrun,
  output logic                        drop_err
);

  localparam int XW = $clog2(WIDTH);
  localparam int AW = $clog2(ROWS);
  localparam int YW = $clog2(2*ROWS);
  localparam int NW = $clog2(WIDTH+1);
  localparam int DW = AW + 6;

  // Handshake: a pixel transfers on a cycle where pix_valid && pix_ready;
  // once raised, pix_valid and the pixel fields hold until that transfer.

  logic clk_sync, clk_rise, clk_fall, clk_any;
  logic lat_sync, lat_rise, lat_fall, lat_any;
  logic oe_sync, oe_rise, oe_fall, oe_any;
  logic [DW-1:0] data_sync, data_rise, data_fall, data_any;

  hub75_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_clk_sync (
    .clock_i(clock), .async_i(hub_clk),
    .sync_o(clk_sync), .rise_o(clk_rise), .fall_o(clk_fall), .any_o(clk_any)
  );
  hub75_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_lat_sync (
    .clock_i(clock), .async_i(hub_lat),
    .sync_o(lat_sync), .rise_o(lat_rise), .fall_o(lat_fall), .any_o(lat_any)
  );
  hub75_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_oe_sync (
    .clock_i(clock), .async_i(hub_oe),
    .sync_o(oe_sync), .rise_o(oe_rise), .fall_o(oe_fall), .any_o(oe_any)
  );
  hub75_sync_edge #(.W(DW), .STAGES(SYNC_STAGES)) u_data_sync (
    .clock_i(clock), .async_i({hub_addr, hub_rgb1, hub_rgb2}),
    .sync_o(data_sync), .rise_o(data_rise), .fall_o(data_fall), .any_o(data_any)
  );

  logic unused_edges;
  assign unused_edges = ^{clk_sync, clk_fall, clk_any, lat_sync, lat_fall,
                          oe_rise, oe_fall, oe_any, data_rise, data_fall, data_any};

  logic [AW-1:0] addr_sync;
  rgb_t          rgb1_sync, rgb2_sync;
  assign addr_sync = data_sync[DW-1:6];
  assign rgb1_sync = data_sync[5:3];
  assign rgb2_sync = data_sync[2:0];

  logic lat_evt;
  assign lat_evt = LATCH_ANY_EDGE ? lat_any : lat_rise;

  line_pix_t     line_q [2][WIDTH];
  logic          cap_sel_q, cap_sel_d;
  logic [NW-1:0] n_q, n_d, n_shift;
  logic [NW-1:0] len_q, len_d;
  logic [XW-1:0] k_q, k_d;
  logic [AW-1:0] row_q, row_d;
  emit_state_t   state_q, state_d;
  logic [15:0]   rows_latched_q;
  logic          overrun_q, drop_q, panel_on_q;

  logic shift_ok, commit, accept, k_last;

  assign shift_ok = clk_rise && (n_q < NW'(WIDTH));
  // A shift landing in the latch cycle belongs to the committed line.
  assign n_shift  = shift_ok ? n_q + NW'(1) : n_q;
  assign commit   = lat_evt && (state_q == IDLE);
  assign accept   = pix_valid && pix_ready;
  assign k_last   = ((NW'(k_q) + NW'(1)) == len_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    row_d     = row_q;
    cap_sel_d = cap_sel_q;
    n_d       = lat_evt ? '0 : n_shift;
    if (commit) begin
      cap_sel_d = ~cap_sel_q;
      len_d     = n_shift;
      row_d     = addr_sync;
      k_d       = '0;
      state_d   = (n_shift == '0) ? IDLE : EMIT_UPPER;
    end else if (accept) begin
      if (k_last) begin
        k_d     = '0;
        state_d = (state_q == EMIT_UPPER) ? EMIT_LOWER : IDLE;
      end else begin
        k_d = k_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      k_q            <= '0;
      len_q          <= '0;
      row_q          <= '0;
      cap_sel_q      <= 1'b0;
      n_q            <= '0;
      rows_latched_q <= '0;
      overrun_q      <= 1'b0;
      drop_q         <= 1'b0;
      panel_on_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      row_q      <= row_d;
      cap_sel_q  <= cap_sel_d;
      n_q        <= n_d;
      panel_on_q <= ~oe_sync;
      if (lat_evt) rows_latched_q <= rows_latched_q + 16'd1;
      if (clk_rise && (n_q == NW'(WIDTH))) overrun_q <= 1'b1;
      if (lat_evt && (state_q != IDLE)) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (shift_ok) line_q[cap_sel_q][n_q[XW-1:0]] <= '{upper: rgb1_sync, lower: rgb2_sync};
  end

  line_pix_t emit_ent;
  assign emit_ent  = line_q[~cap_sel_q][k_q];
  assign pix_valid = (state_q != IDLE);

  // The last-shifted bit sits at column WIDTH-1, so a short line is right-aligned.
  always_comb begin
    pix_x   = '0;
    pix_y   = '0;
    pix_rgb = '0;
    pix_sof = 1'b0;
    if (pix_valid) begin
      pix_x   = XW'(WIDTH - int'(len_q) + int'(k_q));
      pix_y   = (state_q == EMIT_LOWER) ? YW'(row_q) + YW'(ROWS) : YW'(row_q);
      pix_rgb = (state_q == EMIT_LOWER) ? emit_ent.lower : emit_ent.upper;
      pix_sof = (state_q == EMIT_UPPER) && (k_q == '0) && (row_q == '0);
    end
  end

  assign panel_on     = panel_on_q;
  assign rows_latched = rows_latched_q;
  assign overrun      = overrun_q;
  assign drop_err     = drop_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: drives HUB75 lines, predicts the pixel stream
// from the panel rules and checks it on every handshake.
`timescale 1ns/1ps
module tb_hub75_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] hub_addr = '0;
  logic       hub_clk = 1'b0;
  logic [2:0] hub_rgb1 = '0;
  logic [2:0] hub_rgb2 = '0;
  logic       hub_oe = 1'b1;
  logic       hub_lat = 1'b0;
  logic       pix_ready = 1'b1;
  logic       pix_valid;
  logic [5:0] pix_x;
  logic [5:0] pix_y;
  logic [2:0] pix_rgb;
  logic       pix_sof;
  logic       panel_on;
  logic [15:0] rows_latched;
  logic       overrun;
  logic       drop_err;

  always #5 clock = ~clock;

  hub75_rx dut (
    .clock(clock), .reset(reset), .hub_addr(hub_addr), .hub_clk(hub_clk),
    .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2), .hub_oe(hub_oe), .hub_lat(hub_lat),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .pix_sof(pix_sof), .panel_on(panel_on),
    .rows_latched(rows_latched), .overrun(overrun), .drop_err(drop_err)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  // Expected pixel entry: {sof, x[5:0], y[5:0], rgb[2:0]}
  logic [15:0] exp_q[$];
  logic [2:0]  m_up[64];
  logic [2:0]  m_lo[64];
  int          m_n = 0;
  logic        stall_q = 1'b0;
  logic [15:0] stall_v = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, between input updates and the
  // rising edge that performs the transfer.
  always @(negedge clock) begin
    logic [15:0] got;
    logic [15:0] e;
    got = {pix_sof, pix_x, pix_y, pix_rgb};
    if (reset) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) chk("stall_hold", {15'd0, pix_valid, got}, {15'd0, 1'b1, stall_v});
      stall_q = 1'b0;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pixel: got x=%0d y=%0d rgb=%b, expected no pixel", pix_x, pix_y, pix_rgb);
        end else if (pix_ready) begin
          e = exp_q.pop_front();
          checks++;
          hs_cnt++;
          if (got !== e) begin
            errors++;
            $display("FAIL pixel: got sof=%b x=%0d y=%0d rgb=%b expected sof=%b x=%0d y=%0d rgb=%b",
                     got[15], got[14:9], got[8:3], got[2:0], e[15], e[14:9], e[8:3], e[2:0]);
          end
        end else begin
          stall_q = 1'b1;
          stall_v = got;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift(input logic [2:0] u, input logic [2:0] l);
    hub_rgb1 = u;
    hub_rgb2 = l;
    repeat (4) tick();
    hub_clk = 1'b1;
    if (m_n < 64) begin
      m_up[m_n] = u;
      m_lo[m_n] = l;
      m_n++;
    end
    repeat (4) tick();
    hub_clk = 1'b0;
  endtask

  // A latch replays the captured columns right-aligned, upper then lower,
  // unless the previous line is still being emitted.
  task automatic latch(input logic [4:0] a);
    logic [5:0] x;
    hub_addr = a;
    repeat (4) tick();
    hub_lat = ~hub_lat;
    if (exp_q.size() == 0) begin
      for (int k = 0; k < m_n; k++) begin
        x = 6'(64 - m_n + k);
        exp_q.push_back({(a == 5'd0) && (k == 0), x, {1'b0, a}, m_up[k]});
      end
      for (int k = 0; k < m_n; k++) begin
        x = 6'(64 - m_n + k);
        exp_q.push_back({1'b0, x, {1'b1, a}, m_lo[k]});
      end
    end
    m_n = 0;
  endtask

  task automatic drain(input bit rnd);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      t++;
    end
    pix_ready = 1'b1;
    chk("drain_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (6) tick();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (5) tick();
    chk("rst_valid", pix_valid, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_rgb", pix_rgb, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_panel_on", panel_on, 0);
    chk("rst_rows", rows_latched, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_drop", drop_err, 0);
    reset = 1'b0;
    hub_oe = 1'b0;
    repeat (8) tick();
    chk("panel_on", panel_on, 1);

    // Full line, addr 5
    for (int i = 0; i < 64; i++) shift(3'b100, 3'b001);
    latch(5'd5);
    chk("t1_model_len", exp_q.size(), 128);
    chk("t1_model_first", exp_q[0], {1'b0, 6'd0, 6'd5, 3'b100});
    chk("t1_model_lower", exp_q[64], {1'b0, 6'd0, 6'd37, 3'b001});
    hs_cnt = 0;
    drain(1'b0);
    chk("t1_handshakes", hs_cnt, 128);
    chk("t1_rows", rows_latched, 1);
    chk("t1_overrun", overrun, 0);
    chk("t1_drop", drop_err, 0);

    // Full line, addr 0, random backpressure
    for (int i = 0; i < 64; i++) shift(3'b100, 3'b001);
    latch(5'd0);
    chk("t2_model_sof", exp_q[0], {1'b1, 6'd0, 6'd0, 3'b100});
    hs_cnt = 0;
    drain(1'b1);
    chk("t2_handshakes", hs_cnt, 128);
    chk("t2_rows", rows_latched, 2);

    // 70 shifts: the last 6 are lost
    for (int i = 0; i < 70; i++) shift(3'(i), ~3'(i));
    latch(5'd12);
    chk("t3_model_len", exp_q.size(), 128);
    chk("t3_model_last_upper", exp_q[63], {1'b0, 6'd63, 6'd12, 3'd7});
    drain(1'b0);
    chk("t3_overrun", overrun, 1);
    chk("t3_rows", rows_latched, 3);
    chk("t3_drop", drop_err, 0);

    // Second line latched while the first is stalled
    pix_ready = 1'b0;
    for (int i = 0; i < 64; i++) shift(3'b010, 3'b110);
    latch(5'd7);
    for (int i = 0; i < 64; i++) shift(3'b001, 3'b011);
    latch(5'd8);
    repeat (6) tick();
    chk("t4_drop", drop_err, 1);
    chk("t4_rows", rows_latched, 5);
    chk("t4_model_len", exp_q.size(), 128);
    hs_cnt = 0;
    drain(1'b0);
    chk("t4_handshakes", hs_cnt, 128);

    // Short line: right-aligned at columns 54..63
    for (int i = 0; i < 10; i++) shift(3'(i), 3'(7 - i));
    latch(5'd20);
    chk("t5_model_len", exp_q.size(), 20);
    chk("t5_model_first", exp_q[0], {1'b0, 6'd54, 6'd20, 3'd0});
    chk("t5_model_lower", exp_q[10], {1'b0, 6'd54, 6'd52, 3'd7});
    hs_cnt = 0;
    drain(1'b0);
    chk("t5_handshakes", hs_cnt, 20);
    latch(5'd21);
    repeat (12) tick();
    chk("t5_empty_rows", rows_latched, 7);
    chk("t5_empty_valid", pix_valid, 0);

    // Reset in the middle of the upper half
    for (int i = 0; i < 64; i++) shift(3'b111, 3'b010);
    latch(5'd3);
    hs_cnt = 0;
    for (int t = 0; t < 2000 && hs_cnt < 30; t++) tick();
    chk("t6_reached_30", hs_cnt, 30);
    reset = 1'b1;
    tick();
    chk("t6_valid", pix_valid, 0);
    chk("t6_rows", rows_latched, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_drop", drop_err, 0);
    chk("t6_panel_on", panel_on, 0);
    reset = 1'b0;
    m_n = 0;
    repeat (6) tick();
    for (int i = 0; i < 64; i++) shift(3'b110, 3'b011);
    latch(5'd9);
    hs_cnt = 0;
    drain(1'b0);
    chk("t6_handshakes", hs_cnt, 128);
    chk("t6_rows_after", rows_latched, 1);
    chk("t6_drop_after", drop_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
